// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: FSM states, frame-format codes
// and the reset bit-period divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  function automatic logic [3:0] data_bits_n(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] code);
    case (code)
      DBITS_5: return 8'h1F;
      DBITS_6: return 8'h3F;
      DBITS_7: return 8'h7F;
      DBITS_8: return 8'hFF;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..D-1 while running and strikes o_Bit_End at D-1.
// The divisor is latched on i_Load so the same block can serve the receiver.
module uart_bit_timer #(
  parameter int CNT_W   = 16,
  parameter int RST_DIV = 868
) (
  input  logic             i_Clock,
  input  logic             i_Rst_L,
  input  logic             i_Clear,
  input  logic             i_Load,
  input  logic [CNT_W-1:0] i_Div,
  output logic             o_Bit_End
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             w_at_end;

  assign w_at_end  = (r_cnt == r_div - ONE);
  assign o_Bit_End = ~i_Clear & w_at_end;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_div <= CNT_W'(RST_DIV);
      r_cnt <= '0;
    end else begin
      if (i_Load) r_div <= i_Div;
      if (i_Clear || w_at_end) r_cnt <= '0;
      else                     r_cnt <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5-8 data bits, none/odd/even parity, 1 or 2
// stop bits and a runtime bit period, all latched when a byte is accepted.
//
//   state     | meaning
//   ST_IDLE   | line high, ready; accepts i_TX_DV
//   ST_START  | start bit (low) for D cycles
//   ST_DATA   | data bits LSB first, r_bit_idx = bit on the line
//   ST_PARITY | parity bit (only when parity is enabled)
//   ST_STOP   | stop bit(s) high; r_bit_idx counts the stop bits
module uart_tx_cfg #(
  parameter int CLK_CNT_W            = 16,
  parameter int DEFAULT_CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_TX_DV,
  input  logic [7:0]           i_TX_Byte,
  input  logic [CLK_CNT_W-1:0] i_Clks_Per_Bit,
  input  logic [1:0]           i_Data_Bits,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Two_Stop,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  import uart_pkg::*;

  state_t               r_state;
  logic [7:0]           r_byte;
  logic [2:0]           r_last_idx;
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 r_two_stop;
  logic [2:0]           r_bit_idx;
  logic                 r_serial;
  logic                 r_active;
  logic                 r_done;

  logic [CLK_CNT_W-1:0] w_div;
  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_par_en;
  logic                 w_par_bit;
  logic [2:0]           w_last_idx;
  logic [2:0]           w_next_idx;

  // Divisors below 2 are clamped so every bit lasts at least two clocks.
  assign w_div      = (i_Clks_Per_Bit < CLK_CNT_W'(2)) ? CLK_CNT_W'(2) : i_Clks_Per_Bit;
  assign w_accept   = (r_state == ST_IDLE) && i_TX_DV;
  assign w_par_en   = !((i_Parity_Mode == PAR_NONE) || (i_Parity_Mode == PAR_RSVD));
  assign w_par_bit  = (^(i_TX_Byte & data_mask(i_Data_Bits))) ^ (i_Parity_Mode == PAR_ODD);
  assign w_last_idx = 3'(data_bits_n(i_Data_Bits) - 4'd1);
  assign w_next_idx = r_bit_idx + 3'd1;

  assign o_TX_Serial = r_serial;
  assign o_TX_Active = r_active;
  assign o_TX_Ready  = ~r_active;
  assign o_TX_Done   = r_done;

  uart_bit_timer #(
    .CNT_W   (CLK_CNT_W),
    .RST_DIV (DEFAULT_CLKS_PER_BIT)
  ) u_bit_timer (
    .i_Clock   (i_Clock),
    .i_Rst_L   (i_Rst_L),
    .i_Clear   (r_state == ST_IDLE),
    .i_Load    (w_accept),
    .i_Div     (w_div),
    .o_Bit_End (w_bit_end)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state    <= ST_IDLE;
      r_byte     <= '0;
      r_last_idx <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_bit_idx  <= '0;
      r_serial   <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_serial <= 1'b1;
          r_active <= 1'b0;
          if (i_TX_DV) begin
            r_byte     <= i_TX_Byte;
            r_last_idx <= w_last_idx;
            r_par_en   <= w_par_en;
            r_par_bit  <= w_par_bit;
            r_two_stop <= i_Two_Stop;
            r_bit_idx  <= '0;
            r_serial   <= 1'b0;
            r_active   <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_serial  <= r_byte[0];
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == r_last_idx) begin
              r_bit_idx <= '0;
              if (r_par_en) begin
                r_serial <= r_par_bit;
                r_state  <= ST_PARITY;
              end else begin
                r_serial <= 1'b1;
                r_state  <= ST_STOP;
              end
            end else begin
              r_serial  <= r_byte[w_next_idx];
              r_bit_idx <= w_next_idx;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_serial  <= 1'b1;
            r_bit_idx <= '0;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (r_two_stop && (r_bit_idx == 3'd0)) begin
              r_bit_idx <= 3'd1;
            end else begin
              r_serial <= 1'b1;
              r_active <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed and random frames compared
// cycle by cycle against a bit-list model of the frame.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dv;
  logic [7:0]  byte_in;
  logic [15:0] cpb;
  logic [1:0]  dbits;
  logic [1:0]  pmode;
  logic        two;
  logic        tx_ready, tx_active, tx_serial, tx_done;

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;

  typedef struct {
    logic [7:0] b;
    logic [1:0] db;
    logic [1:0] pm;
    logic       two_s;
    int         raw;
  } frame_t;

  bit   exp_bits[$];
  logic obs_ser [0:255];
  logic obs_act [0:255];
  logic obs_done[0:255];
  logic obs_rdy [0:255];

  uart_tx_cfg dut (
    .i_Clock        (clk),
    .i_Rst_L        (rst_n),
    .i_TX_DV        (dv),
    .i_TX_Byte      (byte_in),
    .i_Clks_Per_Bit (cpb),
    .i_Data_Bits    (dbits),
    .i_Parity_Mode  (pmode),
    .i_Two_Stop     (two),
    .o_TX_Ready     (tx_ready),
    .o_TX_Active    (tx_active),
    .o_TX_Serial    (tx_serial),
    .o_TX_Done      (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Frame model: list of line levels, one entry per bit period.
  task automatic build_exp(input logic [7:0] b, input logic [1:0] db, input logic [1:0] pm,
                           input logic two_s, input int raw, output int d, output int t);
    int n;
    int ones;
    exp_bits.delete();
    n    = 5 + int'(db);
    ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (pm == 2'b01)      exp_bits.push_back((ones % 2) == 0);
    else if (pm == 2'b10) exp_bits.push_back((ones % 2) == 1);
    exp_bits.push_back(1'b1);
    if (two_s) exp_bits.push_back(1'b1);
    d = (raw < 2) ? 2 : raw;
    t = int'(exp_bits.size()) * d;
  endtask

  task automatic start_frame(input logic [7:0] b, input logic [1:0] db, input logic [1:0] pm,
                             input logic two_s, input int raw);
    @(negedge clk);
    byte_in = b;
    dbits   = db;
    pmode   = pm;
    two     = two_s;
    cpb     = 16'(raw);
    dv      = 1'b1;
    @(posedge clk);
  endtask

  // Samples cycles 0..ncyc-1 after the accept edge; scrambles inputs mid-frame.
  task automatic capture(input int ncyc, input int pulse_c, input bit hold, input logic [7:0] nxt);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      obs_ser[c]  = tx_serial;
      obs_act[c]  = tx_active;
      obs_done[c] = tx_done;
      obs_rdy[c]  = tx_ready;
      if (c == 0) begin
        if (hold) begin
          byte_in = nxt;
        end else begin
          dv      = 1'b0;
          byte_in = 8'($urandom);
          cpb     = 16'($urandom);
          dbits   = 2'($urandom);
          pmode   = 2'($urandom);
          two     = 1'($urandom);
        end
      end
      if (c == pulse_c)                       dv = 1'b1;
      else if (pulse_c >= 0 && c == pulse_c + 1) dv = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dv = 1'b0; byte_in = 8'h00; cpb = 16'd4; dbits = 2'b11; pmode = 2'b00; two = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({tx_serial, tx_active, tx_ready, tx_done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_state ser/act/rdy/done got %b required 1010",
               {tx_serial, tx_active, tx_ready, tx_done});
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({tx_serial, tx_active, tx_ready, tx_done} !== 4'b1010) begin
        n_fail++;
        $display("FAIL idle_after_reset ser/act/rdy/done got %b required 1010",
                 {tx_serial, tx_active, tx_ready, tx_done});
      end
    end
  endtask

  task automatic test_frames();
    frame_t tbl[$];
    int d, t;
    logic e_ser, e_act, e_done;
    tbl.push_back('{8'hA5, 2'b11, 2'b00, 1'b0, 4});
    tbl.push_back('{8'hC1, 2'b10, 2'b10, 1'b0, 4});
    tbl.push_back('{8'hFF, 2'b11, 2'b01, 1'b1, 3});
    tbl.push_back('{8'hE3, 2'b00, 2'b00, 1'b0, 2});
    tbl.push_back('{8'hE3, 2'b00, 2'b00, 1'b0, 0});
    tbl.push_back('{8'h6B, 2'b01, 2'b11, 1'b1, 1});
    for (int k = 0; k < 10; k++)
      tbl.push_back('{8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                      int'($urandom_range(0, 6))});
    foreach (tbl[k]) begin
      build_exp(tbl[k].b, tbl[k].db, tbl[k].pm, tbl[k].two_s, tbl[k].raw, d, t);
      start_frame(tbl[k].b, tbl[k].db, tbl[k].pm, tbl[k].two_s, tbl[k].raw);
      capture(t + 1, -1, 1'b0, 8'h00);
      for (int c = 0; c <= t; c++) begin
        e_ser  = (c < t) ? exp_bits[c / d] : 1'b1;
        e_act  = (c < t);
        e_done = (c == t);
        n_tests++;
        if (obs_ser[c] !== e_ser || obs_act[c] !== e_act || obs_done[c] !== e_done ||
            obs_rdy[c] !== ~e_act) begin
          n_fail++;
          if (n_print < 20)
            $display("FAIL frame%0d byte=%h cyc=%0d ser/act/done/rdy got %b%b%b%b required %b%b%b%b",
                     k, tbl[k].b, c, obs_ser[c], obs_act[c], obs_done[c], obs_rdy[c],
                     e_ser, e_act, e_done, ~e_act);
          n_print++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int d, t;
    logic e_ser, e_act, e_done;
    logic [7:0] bytes [2];
    bytes[0] = 8'h55;
    bytes[1] = 8'hAA;
    start_frame(bytes[0], 2'b11, 2'b00, 1'b0, 4);
    for (int f = 0; f < 2; f++) begin
      build_exp(bytes[f], 2'b11, 2'b00, 1'b0, 4, d, t);
      capture(t + 1, -1, (f == 0), bytes[1]);
      for (int c = 0; c <= t; c++) begin
        e_ser  = (c < t) ? exp_bits[c / d] : 1'b1;
        e_act  = (c < t);
        e_done = (c == t);
        n_tests++;
        if (obs_ser[c] !== e_ser || obs_act[c] !== e_act || obs_done[c] !== e_done ||
            obs_rdy[c] !== ~e_act) begin
          n_fail++;
          if (n_print < 20)
            $display("FAIL b2b frame%0d cyc=%0d ser/act/done/rdy got %b%b%b%b required %b%b%b%b",
                     f, c, obs_ser[c], obs_act[c], obs_done[c], obs_rdy[c],
                     e_ser, e_act, e_done, ~e_act);
          n_print++;
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int d, t;
    logic e_ser, e_act, e_done;
    build_exp(8'h55, 2'b11, 2'b00, 1'b0, 4, d, t);
    start_frame(8'h55, 2'b11, 2'b00, 1'b0, 4);
    capture(t + 6, 10, 1'b0, 8'h00);
    for (int c = 0; c < t + 6; c++) begin
      e_ser  = (c < t) ? exp_bits[c / d] : 1'b1;
      e_act  = (c < t);
      e_done = (c == t);
      n_tests++;
      if (obs_ser[c] !== e_ser || obs_act[c] !== e_act || obs_done[c] !== e_done ||
          obs_rdy[c] !== ~e_act) begin
        n_fail++;
        if (n_print < 20)
          $display("FAIL busy_ignore cyc=%0d ser/act/done/rdy got %b%b%b%b required %b%b%b%b",
                   c, obs_ser[c], obs_act[c], obs_done[c], obs_rdy[c],
                   e_ser, e_act, e_done, ~e_act);
        n_print++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int d, t;
    logic e_ser, e_act, e_done;
    start_frame(8'hA5, 2'b11, 2'b00, 1'b0, 4);
    capture(18, -1, 1'b0, 8'h00);
    n_tests++;
    if (obs_ser[17] !== 1'b0 || obs_act[17] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_bit3 ser/act got %b%b required 01", obs_ser[17], obs_act[17]);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({tx_serial, tx_active, tx_ready, tx_done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_mid_frame ser/act/rdy/done got %b required 1010",
               {tx_serial, tx_active, tx_ready, tx_done});
    end
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({tx_serial, tx_active, tx_ready, tx_done} !== 4'b1010) begin
        n_fail++;
        $display("FAIL held_in_reset ser/act/rdy/done got %b required 1010",
                 {tx_serial, tx_active, tx_ready, tx_done});
      end
    end
    rst_n = 1'b1;
    dv    = 1'b0;
    build_exp(8'h3C, 2'b11, 2'b00, 1'b0, 4, d, t);
    start_frame(8'h3C, 2'b11, 2'b00, 1'b0, 4);
    capture(t + 1, -1, 1'b0, 8'h00);
    for (int c = 0; c <= t; c++) begin
      e_ser  = (c < t) ? exp_bits[c / d] : 1'b1;
      e_act  = (c < t);
      e_done = (c == t);
      n_tests++;
      if (obs_ser[c] !== e_ser || obs_act[c] !== e_act || obs_done[c] !== e_done ||
          obs_rdy[c] !== ~e_act) begin
        n_fail++;
        if (n_print < 20)
          $display("FAIL after_reset cyc=%0d ser/act/done/rdy got %b%b%b%b required %b%b%b%b",
                   c, obs_ser[c], obs_act[c], obs_done[c], obs_rdy[c],
                   e_ser, e_act, e_done, ~e_act);
        n_print++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
